// File: rtl/dqsw_wl_sweep_ctrl.sv
// dqsw_wl_sweep_ctrl
//   Write-leveling sweep sequencer for one DDR4 lane. It fires single DQS
//   strobes through the DQSW training IOD, majority-votes the DQ feedback over
//   SAMPLES strobes per tap, and steps the dynamic delay line up one tap at a
//   time until the first 0->1 feedback transition (DQS aligned to CK).
//
// Ports
//   FAB_CLK                    fabric clock (shared with IOD RX_CLK/TX_CLK)
//   RESET                      asynchronous active-high reset
//   START                      single-cycle sweep request (honoured in IDLE only)
//   WL_FEEDBACK[1:0]           registered DQ RX_DATA; feedback = OR of both bits
//   DELAY_LINE_OUT_OF_RANGE_0  delay line saturated, from the IOD
//   TX_DATA_0[1:0]             DQS strobe data (2'b10 during a strobe)
//   OE_DATA_0[1:0]             DQS output enable (2'b11 during a strobe)
//   DELAY_LINE_MOVE_0          one-cycle tap step
//   DELAY_LINE_DIRECTION_0     step direction, 1 = increment (held while busy)
//   DELAY_LINE_LOAD_0          one-cycle reload of the delay line to tap 0
//   EYE_MONITOR_CLEAR_FLAGS_0  one-cycle pulse at sweep start
//   BUSY                       sweep in progress
//   DONE / ERROR               sticky result flags, cleared by the next START
//   ERR_CODE[1:0]              00 none, 01 no edge found, 10 delay line out of range
//   TAP_COUNT[TAP_W-1:0]       live tap while busy; aligned tap once DONE
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for START
// LOAD      | reload delay line to tap 0, clear eye-monitor flags
// STROBE    | drive one DQS strobe
// SETTLE    | wait SETTLE_CYCLES for the feedback to come back
// SAMPLE    | accumulate one feedback vote
// DECIDE    | majority result; edge found, sweep exhausted, or step on
// STEP      | pulse MOVE (increment)
// STEP_WAIT | two cycles for the line to settle, then check out-of-range
// FINISH    | one-cycle exit, flags already latched

module dqsw_wl_sweep_ctrl #(
    parameter int MAX_TAPS      = 128,
    parameter int TAP_W         = 7,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 5
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       WL_FEEDBACK,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    output logic [1:0]       TX_DATA_0,
    output logic [1:0]       OE_DATA_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             DELAY_LINE_LOAD_0,
    output logic             EYE_MONITOR_CLEAR_FLAGS_0,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic [1:0]       ERR_CODE,
    output logic [TAP_W-1:0] TAP_COUNT
);

    localparam int CNT_W = $clog2(SAMPLES + 1);
    localparam int TMR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // Timer is a down-counter; loading N-1 gives exactly N cycles in the state.
    localparam logic [TMR_W-1:0] SETTLE_LOAD    = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] STEP_WAIT_LOAD = TMR_W'(1);
    localparam logic [CNT_W-1:0] LAST_STROBE    = CNT_W'(SAMPLES - 1);
    localparam logic [CNT_W-1:0] VOTE_HALF      = CNT_W'(SAMPLES / 2);
    localparam logic [TAP_W-1:0] LAST_TAP       = TAP_W'(MAX_TAPS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_STROBE, S_SETTLE, S_SAMPLE,
        S_DECIDE, S_STEP, S_STEP_WAIT, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [CNT_W-1:0]   vote_q, vote_d;
    logic [CNT_W-1:0]   strobe_q, strobe_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               prev_q, prev_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [1:0]         err_code_q, err_code_d;

    logic               fb_bit;
    logic               tap_result;

    assign fb_bit     = |WL_FEEDBACK;
    assign tap_result = (vote_q > VOTE_HALF);

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            tap_q      <= '0;
            vote_q     <= '0;
            strobe_q   <= '0;
            timer_q    <= '0;
            prev_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            vote_q     <= vote_d;
            strobe_q   <= strobe_d;
            timer_q    <= timer_d;
            prev_q     <= prev_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        vote_d     = vote_q;
        strobe_d   = strobe_q;
        timer_d    = timer_q;
        prev_d     = prev_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d    = S_LOAD;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'b00;
                    tap_d      = '0;
                end
            end
            S_LOAD: begin
                tap_d    = '0;
                prev_d   = 1'b1;   // a tap-0 "1" must not count as an edge
                vote_d   = '0;
                strobe_d = '0;
                state_d  = S_STROBE;
            end
            S_STROBE: begin
                timer_d = SETTLE_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_q == '0) state_d = S_SAMPLE;
                else               timer_d = timer_q - 1'b1;
            end
            S_SAMPLE: begin
                vote_d   = vote_q + CNT_W'(fb_bit);
                strobe_d = strobe_q + 1'b1;
                state_d  = (strobe_q == LAST_STROBE) ? S_DECIDE : S_STROBE;
            end
            S_DECIDE: begin
                if (!prev_q && tap_result) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (tap_q == LAST_TAP) begin
                    error_d    = 1'b1;
                    err_code_d = 2'b01;
                    state_d    = S_FINISH;
                end else begin
                    prev_d   = tap_result;
                    vote_d   = '0;
                    strobe_d = '0;
                    state_d  = S_STEP;
                end
            end
            S_STEP: begin
                timer_d = STEP_WAIT_LOAD;
                state_d = S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (DELAY_LINE_OUT_OF_RANGE_0) begin
                    error_d    = 1'b1;
                    err_code_d = 2'b10;
                    state_d    = S_FINISH;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = S_STROBE;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        TX_DATA_0                 = 2'b00;
        OE_DATA_0                 = 2'b00;
        DELAY_LINE_MOVE_0         = 1'b0;
        DELAY_LINE_LOAD_0         = 1'b0;
        EYE_MONITOR_CLEAR_FLAGS_0 = 1'b0;
        BUSY                      = 1'b1;
        case (state_q)
            S_IDLE, S_FINISH: BUSY = 1'b0;
            S_LOAD: begin
                DELAY_LINE_LOAD_0         = 1'b1;
                EYE_MONITOR_CLEAR_FLAGS_0 = 1'b1;
            end
            S_STROBE: begin
                TX_DATA_0 = 2'b10;
                OE_DATA_0 = 2'b11;
            end
            S_STEP:  DELAY_LINE_MOVE_0 = 1'b1;
            default: ;
        endcase
        DELAY_LINE_DIRECTION_0 = BUSY;
    end

    assign DONE      = done_q;
    assign ERROR     = error_q;
    assign ERR_CODE  = err_code_q;
    assign TAP_COUNT = tap_q;

endmodule

// File: tb/tb_dqsw_wl_sweep_ctrl.sv
// Bench for dqsw_wl_sweep_ctrl: an IOD-like responder returns feedback per
// (tap, strobe) from a pattern table; a sweep-level model predicts the result.
module tb_dqsw_wl_sweep_ctrl;

    localparam int MAX_TAPS = 128;
    localparam int TAP_W    = 7;
    localparam int SETTLE   = 8;
    localparam int SAMPLES  = 5;

    logic             FAB_CLK = 1'b0;
    logic             RESET   = 1'b1;
    logic             START   = 1'b0;
    logic [1:0]       WL_FEEDBACK = 2'b00;
    logic             OOR = 1'b0;
    logic [1:0]       TX_DATA_0, OE_DATA_0;
    logic             MOVE, DIR, LOAD, CLR, BUSY, DONE, ERROR;
    logic [1:0]       ERR_CODE;
    logic [TAP_W-1:0] TAP_COUNT;

    dqsw_wl_sweep_ctrl #(
        .MAX_TAPS(MAX_TAPS), .TAP_W(TAP_W), .SETTLE_CYCLES(SETTLE), .SAMPLES(SAMPLES)
    ) dut (
        .FAB_CLK(FAB_CLK), .RESET(RESET), .START(START), .WL_FEEDBACK(WL_FEEDBACK),
        .DELAY_LINE_OUT_OF_RANGE_0(OOR), .TX_DATA_0(TX_DATA_0), .OE_DATA_0(OE_DATA_0),
        .DELAY_LINE_MOVE_0(MOVE), .DELAY_LINE_DIRECTION_0(DIR), .DELAY_LINE_LOAD_0(LOAD),
        .EYE_MONITOR_CLEAR_FLAGS_0(CLR), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .ERR_CODE(ERR_CODE), .TAP_COUNT(TAP_COUNT)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // feedback pattern per tap / strobe, and the move count at which the line saturates (0 = never)
    bit pat [MAX_TAPS][SAMPLES];
    int oor_at = 0;

    // IOD-like responder and event counters
    int load_cnt = 0, clr_cnt = 0, move_cnt = 0, busy_cnt = 0;
    int both_cnt = 0, dir_bad = 0, strobe_bad = 0;
    int tap_idx = 0, sidx = 0, moves_since = 0;

    always @(negedge FAB_CLK) begin
        if (LOAD) begin
            load_cnt++;
            tap_idx = 0; sidx = 0; moves_since = 0;
            OOR = 1'b0;
        end
        if (CLR) clr_cnt++;
        if (MOVE) begin
            move_cnt++; moves_since++; tap_idx++; sidx = 0;
            if (!DIR) dir_bad++;
            if (oor_at != 0 && moves_since == oor_at) OOR = 1'b1;
        end
        if (TX_DATA_0 == 2'b10) begin
            if (OE_DATA_0 != 2'b11) strobe_bad++;
            if (tap_idx < MAX_TAPS && sidx < SAMPLES && pat[tap_idx][sidx])
                WL_FEEDBACK = 2'($urandom_range(1, 3));
            else
                WL_FEEDBACK = 2'b00;
            sidx++;
        end else if (TX_DATA_0 != 2'b00 || OE_DATA_0 != 2'b00) begin
            strobe_bad++;
        end
        if (BUSY) busy_cnt++;
        if (DONE && ERROR) both_cnt++;
    end

    // Sweep-level reference: walk the taps with the majority/edge rules.
    task automatic model(output bit e_done, output bit e_err, output logic [1:0] e_code,
                         output int e_tap, output int e_moves, output int e_busy);
        bit prev = 1'b1;
        e_done = 0; e_err = 0; e_code = 2'b00; e_tap = 0; e_moves = 0; e_busy = 1;
        for (int t = 0; t < MAX_TAPS; t++) begin
            int votes = 0;
            bit res;
            for (int s = 0; s < SAMPLES; s++) votes += int'(pat[t][s]);
            res = (2 * votes > SAMPLES);
            e_busy += SAMPLES * (SETTLE + 2) + 1;
            e_tap = t;
            if (!prev && res) begin e_done = 1; return; end
            if (t == MAX_TAPS - 1) begin e_err = 1; e_code = 2'b01; return; end
            prev = res;
            e_moves++;
            e_busy += 3;
            if (oor_at != 0 && e_moves == oor_at) begin e_err = 1; e_code = 2'b10; return; end
        end
    endtask

    task automatic set_tap(input int t, input bit b);
        for (int s = 0; s < SAMPLES; s++) pat[t][s] = b;
    endtask

    task automatic run_sweep(input string name, input int busy_start_at);
        bit e_done, e_err, seen;
        logic [1:0] e_code;
        int e_tap, e_moves, e_busy;
        int l0, c0, m0, b0;
        model(e_done, e_err, e_code, e_tap, e_moves, e_busy);
        l0 = load_cnt; c0 = clr_cnt; m0 = move_cnt; b0 = busy_cnt;
        check_val({name, ":dir_idle"}, 32'(DIR), 32'(0));
        @(negedge FAB_CLK); START = 1'b1;
        @(negedge FAB_CLK); START = 1'b0;
        check_val({name, ":start"}, 32'({LOAD, CLR, BUSY, DONE, ERROR, ERR_CODE, TAP_COUNT}),
                  32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0}));
        seen = 0;
        for (int c = 0; c < MAX_TAPS * 60 + 100; c++) begin
            @(negedge FAB_CLK);
            START = (busy_start_at > 0 && c == busy_start_at);
            if (DONE || ERROR) begin seen = 1; break; end
        end
        START = 1'b0;
        @(negedge FAB_CLK);
        check_val({name, ":finished"}, 32'(seen), 32'(1));
        check_val({name, ":done"}, 32'(DONE), 32'(e_done));
        check_val({name, ":error"}, 32'(ERROR), 32'(e_err));
        check_val({name, ":err_code"}, 32'(ERR_CODE), 32'(e_code));
        check_val({name, ":tap_count"}, 32'(TAP_COUNT), 32'(e_tap));
        check_val({name, ":busy_end"}, 32'(BUSY), 32'(0));
        check_val({name, ":moves"}, 32'(move_cnt - m0), 32'(e_moves));
        check_val({name, ":loads"}, 32'(load_cnt - l0), 32'(1));
        check_val({name, ":clears"}, 32'(clr_cnt - c0), 32'(1));
        check_val({name, ":busy_cycles"}, 32'(busy_cnt - b0), 32'(e_busy));
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({BUSY, DONE, ERROR, ERR_CODE, TAP_COUNT, TX_DATA_0, OE_DATA_0,
                    MOVE, DIR, LOAD, CLR});
    endfunction

    initial begin
        bit reached;
        repeat (3) @(negedge FAB_CLK);
        check_val("reset_vals", out_vec(), 32'(0));
        RESET = 1'b0;
        @(negedge FAB_CLK);
        check_val("idle_vals", out_vec(), 32'(0));

        // edge at tap 41 after an early high region
        for (int t = 0; t < MAX_TAPS; t++) set_tap(t, (t < 3) || (t >= 41));
        run_sweep("edge41", 0);

        // same sweep with a START pulse while busy, then a START right after DONE
        run_sweep("busy_start", 200);

        // feedback stuck low: no edge
        for (int t = 0; t < MAX_TAPS; t++) set_tap(t, 1'b0);
        run_sweep("stuck0", 0);

        // delay line saturates after the 10th move
        oor_at = 10;
        run_sweep("oor10", 0);
        oor_at = 0;

        // majority vote at tap 15
        for (int t = 0; t < MAX_TAPS; t++) set_tap(t, (t < 14) || (t > 15));
        set_tap(14, 1'b0);
        pat[15][0] = 1; pat[15][1] = 0; pat[15][2] = 1; pat[15][3] = 1; pat[15][4] = 0;
        run_sweep("maj_10110", 0);
        pat[15][2] = 0;
        run_sweep("maj_10010", 0);

        // reset in the middle of SETTLE at tap 20
        for (int t = 0; t < MAX_TAPS; t++) set_tap(t, 1'b0);
        @(negedge FAB_CLK); START = 1'b1;
        @(negedge FAB_CLK); START = 1'b0;
        reached = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge FAB_CLK);
            if (tap_idx == 20 && sidx == 1) begin reached = 1; break; end
        end
        check_val("reach_tap20", 32'(reached), 32'(1));
        repeat (3) @(negedge FAB_CLK);
        #2 RESET = 1'b1;
        #1 check_val("mid_reset_vals", out_vec(), 32'(0));
        @(negedge FAB_CLK);
        @(negedge FAB_CLK); RESET = 1'b0;
        for (int t = 0; t < MAX_TAPS; t++) set_tap(t, (t >= 6));
        set_tap(0, 1'b1);
        run_sweep("after_reset", 0);

        // randomized sweeps
        for (int n = 0; n < 6; n++) begin
            int edge_t = $urandom_range(0, 70);
            for (int t = 0; t < MAX_TAPS; t++) begin
                bit base = (t >= edge_t) ? 1'b1 : ($urandom_range(0, 3) == 0);
                for (int s = 0; s < SAMPLES; s++)
                    pat[t][s] = base ^ ($urandom_range(0, 7) == 0);
            end
            oor_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            run_sweep($sformatf("rand%0d", n), (n == 2) ? 75 : 0);
        end
        oor_at = 0;

        check_val("done_and_error", 32'(both_cnt), 32'(0));
        check_val("dir_on_move", 32'(dir_bad), 32'(0));
        check_val("strobe_shape", 32'(strobe_bad), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dqsw_wl_sweep_ctrl.md
Name: dqsw_wl_sweep_ctrl

Overview:
- Fabric-side write-leveling sequencer that feeds the DQSW training IOD of one DDR4 lane.
- Drives the IOD's TX_DATA/OE_DATA with single DQS strobes and walks its dynamic delay line one tap at a time using MOVE, DIRECTION and LOAD.
- Samples the DQ write-leveling feedback at each tap and stops at the first 0->1 transition, which marks DQS aligned to CK.
- Reports the aligned tap count, or an error, to the training controller.

Parameters:
- MAX_TAPS, 128, number of delay-line taps swept; the sweep fails if no edge is found by the last tap.
- TAP_W, 7, width of the tap counter and TAP_COUNT; must satisfy 2^TAP_W >= MAX_TAPS.
- SETTLE_CYCLES, 8, FAB_CLK cycles waited after each strobe before sampling feedback (>=1).
- SAMPLES, 5, strobes per tap for majority vote; must be odd and >=1.

Ports:
- FAB_CLK  in  1  fabric clock, shared with the IOD RX_CLK/TX_CLK.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request to begin a sweep.
- WL_FEEDBACK  in  2  registered RX_DATA of the lane's DQ IOD; feedback bit = OR of both bits.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from the IOD.
- TX_DATA_0  out  2  DQS strobe data to the IOD.
- OE_DATA_0  out  2  DQS output-enable data to the IOD.
- DELAY_LINE_MOVE_0  out  1  one-cycle tap step.
- DELAY_LINE_DIRECTION_0  out  1  step direction; 1 = increment.
- DELAY_LINE_LOAD_0  out  1  one-cycle reload of the delay line to its static value (tap 0).
- EYE_MONITOR_CLEAR_FLAGS_0  out  1  one-cycle pulse at sweep start.
- BUSY  out  1  high from the cycle after an accepted START until DONE or ERROR is set.
- DONE  out  1  sticky success flag; cleared by the next START.
- ERROR  out  1  sticky failure flag; cleared by the next START.
- ERR_CODE  out  2  00 none, 01 no edge within MAX_TAPS, 10 delay line out of range.
- TAP_COUNT  out  TAP_W  current tap during the sweep; the aligned tap once DONE is set.

Behaviour:
- Reset values: every output is 0, including TX_DATA_0, OE_DATA_0, TAP_COUNT and ERR_CODE. State is IDLE and all internal counters are cleared.
- Reset asserted mid-sweep aborts immediately to the reset values. No delay-line restore is attempted; the next sweep's LOAD re-initialises the line.
- States: IDLE, LOAD, STROBE, SETTLE, SAMPLE, DECIDE, STEP, STEP_WAIT, FINISH.
- IDLE: on START, go to LOAD and clear DONE, ERROR and ERR_CODE. START seen in any other state is ignored.
- LOAD (1 cycle): DELAY_LINE_LOAD_0=1 and EYE_MONITOR_CLEAR_FLAGS_0=1. Set tap=0, prev=1, vote=0 and strobe counter=0. Go to STROBE.
- STROBE (1 cycle): TX_DATA_0=2'b10, OE_DATA_0=2'b11. In every other state both are 2'b00. Go to SETTLE.
- SETTLE: wait exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle): vote += (|WL_FEEDBACK) and strobe counter++. If strobe counter < SAMPLES, go to STROBE; otherwise go to DECIDE.
- Per-tap time is SAMPLES*(SETTLE_CYCLES+2) cycles.
- DECIDE (1 cycle): result = (vote > SAMPLES/2).
  - If prev==0 and result==1: latch TAP_COUNT=tap, set DONE, go to FINISH.
  - Else if tap==MAX_TAPS-1: set ERROR with ERR_CODE=01, go to FINISH.
  - Else: set prev=result, clear vote and strobe counter, go to STEP.
- prev starts at 1, so a tap-0 result of 1 is not an edge; a 0 must be seen first.
- STEP (1 cycle): DELAY_LINE_MOVE_0=1 and DELAY_LINE_DIRECTION_0=1. Go to STEP_WAIT.
- DIRECTION is held at 1 throughout the sweep and is 0 in IDLE.
- STEP_WAIT (2 cycles): on the second cycle, sample DELAY_LINE_OUT_OF_RANGE_0.
  - If high: set ERROR with ERR_CODE=10 and go to FINISH. TAP_COUNT holds the tap reached.
  - Else: tap++ and go to STROBE.
- FINISH: BUSY=0, flags held, go to IDLE in the same cycle. DONE and ERROR are never set together.
- TAP_COUNT tracks tap continuously while BUSY and freezes when the sweep ends.
- The tap counter never wraps: the MAX_TAPS-1 check precedes any increment.

Test Plan:
- RESET mid-SETTLE at tap 20 -> all outputs 0 at once. A new START gives a LOAD pulse and TAP_COUNT restarts at 0.
- Feedback 1 for taps 0-2, 0 for taps 3-40, 1 from tap 41; START -> DONE=1, TAP_COUNT=41, ERROR=0. Exactly 41 MOVE pulses, 1 LOAD pulse, 1 CLEAR_FLAGS pulse.
- Feedback stuck 0 with MAX_TAPS=128 -> ERROR=1, ERR_CODE=01, TAP_COUNT=127, DONE=0. 127 MOVE pulses.
- Feedback 0 everywhere, OUT_OF_RANGE raised after the 10th MOVE -> ERROR=1, ERR_CODE=10, TAP_COUNT=9, no further MOVE pulses.
- Tap 15 feedback pattern 1,0,1,1,0 over the 5 strobes, tap 14 all 0, SAMPLES=5 -> majority 1, DONE at TAP_COUNT=15. Pattern 1,0,0,1,0 instead -> sweep continues.
- START pulses during BUSY and while DONE=1 -> the busy pulses are ignored. The post-DONE START clears DONE, and BUSY rises on the next cycle.
